// File: rtl/functional_unit_elastic.sv
// functional_unit_elastic
//   CGRA processing element: two-operand ALU with a windowed accumulate
//   (feedback) mode and a 2-entry elastic output buffer.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   din_1, din_2    operands A and B (B is replaced by the accumulator in feedback mode)
//   din_v / din_r   input handshake
//   dout / dout_v   buffer head data / buffer non-empty
//   dout_r          downstream ready
//   feedback        0 = streaming, 1 = accumulate over a window
//   initial_value   accumulator seed loaded at the start of each window
//   delay_value     accepted samples per window (0 behaves as 1)
//   alu_sel         opcode
//   window_done     one-cycle pulse, aligned with the push of a window result
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// din_r is derived from registered state (FSM, buffer full flag), the
// feedback mode input and rst only; it never looks at dout_r.
//
// Configuration macro: FU_MUL_EN. When defined, opcode 1 is a multiplier
// (low DATA_WIDTH bits of a*b). When undefined, opcode 1 decodes as add.
//
// The FSM state is held in state_q (typed state_t) for observation.
module functional_unit_elastic #(
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_WIDTH-1:0]  din_1,
   input  logic [DATA_WIDTH-1:0]  din_2,
   input  logic                   din_v,
   output logic                   din_r,
   output logic [DATA_WIDTH-1:0]  dout,
   output logic                   dout_v,
   input  logic                   dout_r,
   input  logic                   feedback,
   input  logic [DATA_WIDTH-1:0]  initial_value,
   input  logic [COUNT_WIDTH-1:0] delay_value,
   input  logic [3:0]             alu_sel,
   output logic                   window_done
);

   localparam int SHW = $clog2(DATA_WIDTH);
   localparam logic [COUNT_WIDTH:0] CNT_ONE = (COUNT_WIDTH+1)'(1);

   typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  acc_q, acc_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   window_done_d;

   logic [DATA_WIDTH-1:0]  buf_mem [2];
   logic                   wr_ptr, rd_ptr;
   logic [1:0]             occ_q;
   logic                   full;

   logic [DATA_WIDTH-1:0]  op_b, result;
   logic [SHW-1:0]         shamt;
   logic                   a_lt_b;
   logic                   accept, pop, push, last_sample;
   logic [COUNT_WIDTH:0]   cnt_next, window_len;

   // ---------------- ALU ----------------
   assign op_b   = (state_q == ACC) ? acc_q : din_2;
   assign shamt  = op_b[SHW-1:0];
   assign a_lt_b = $signed(din_1) < $signed(op_b);

   always_comb begin
      result = din_1 + op_b;
      case (alu_sel)
`ifdef FU_MUL_EN
         4'd1:    result = din_1 * op_b;
`else
         4'd1:    result = din_1 + op_b;
`endif
         4'd2:    result = din_1 - op_b;
         4'd3:    result = din_1 & op_b;
         4'd4:    result = din_1 | op_b;
         4'd5:    result = din_1 ^ op_b;
         4'd6:    result = din_1 << shamt;
         4'd7:    result = din_1 >> shamt;
         4'd8:    result = $unsigned($signed(din_1) >>> shamt);
         4'd9:    result = a_lt_b ? din_1 : op_b;
         4'd10:   result = a_lt_b ? op_b : din_1;
         4'd11:   result = {{(DATA_WIDTH-1){1'b0}}, a_lt_b};
         default: result = din_1 + op_b;
      endcase
   end

   // ---------------- handshake ----------------
   assign full   = occ_q[1];
   assign dout_v = (occ_q != 2'd0);
   assign dout   = buf_mem[rd_ptr];

   // IDLE accepts only in streaming; ACC accepts only while feedback holds,
   // so dropping feedback mid-window discards the partial window cleanly.
   always_comb begin
      din_r = 1'b0;
      if (!rst && !full) begin
         if (state_q == IDLE) din_r = !feedback;
         else                 din_r = feedback;
      end
   end

   assign accept      = din_v && din_r;
   assign pop         = dout_v && dout_r;
   assign window_len  = (delay_value == '0) ? CNT_ONE : {1'b0, delay_value};
   assign cnt_next    = {1'b0, cnt_q} + CNT_ONE;
   assign last_sample = (cnt_next >= window_len);
   assign push        = accept && ((state_q == IDLE) || last_sample);

   // ---------------- FSM ----------------
   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      cnt_d         = cnt_q;
      window_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            // Reseed cycle: din_r is low here, nothing is accepted.
            if (feedback) begin
               acc_d   = initial_value;
               cnt_d   = '0;
               state_d = ACC;
            end
         end
         ACC: begin
            if (!feedback) begin
               state_d = IDLE;
            end else if (accept) begin
               if (last_sample) begin
                  window_done_d = 1'b1;
                  state_d       = IDLE;
               end else begin
                  acc_d = result;
                  cnt_d = cnt_next[COUNT_WIDTH-1:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         window_done <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         window_done <= window_done_d;
      end
   end

   // ---------------- output buffer ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_mem[0] <= '0;
         buf_mem[1] <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         occ_q      <= 2'd0;
      end else begin
         if (push) begin
            buf_mem[wr_ptr] <= result;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   occ_q <= occ_q + 2'd1;
            2'b01:   occ_q <= occ_q - 2'd1;
            default: occ_q <= occ_q;
         endcase
      end
   end

endmodule

// File: tb/tb_functional_unit_elastic.sv
// Testbench for functional_unit_elastic (DATA_WIDTH=32, COUNT_WIDTH=16).
// A transaction-level model predicts din_r, dout_v, dout and window_done
// each cycle; directed groups follow the test plan, then a random phase.
module tb_functional_unit_elastic;

   localparam int DW = 32;
   localparam int CW = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [DW-1:0] din_1 = '0, din_2 = '0, dout, initial_value = '0;
   logic          din_v = 1'b0, din_r, dout_v, dout_r = 1'b0, feedback = 1'b0, window_done;
   logic [CW-1:0] delay_value = '0;
   logic [3:0]    alu_sel = '0;

   functional_unit_elastic #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .din_1         (din_1),
      .din_2         (din_2),
      .din_v         (din_v),
      .din_r         (din_r),
      .dout          (dout),
      .dout_v        (dout_v),
      .dout_r        (dout_r),
      .feedback      (feedback),
      .initial_value (initial_value),
      .delay_value   (delay_value),
      .alu_sel       (alu_sel),
      .window_done   (window_done)
   );

   // ---------------- scoreboard / model state ----------------
   int            n_tests = 0;
   int            n_fail  = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_q[$];
   bit            m_in_window = 1'b0;
   logic [DW-1:0] m_acc = '0;
   int            m_n = 0;
   bit            m_wd_exp = 1'b0;
   int            wd_seen = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] ref_op(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
      int sa, sb, sh;
      sa = a;
      sb = b;
      sh = int'(b % DW);
      case (op)
         4'd0:  return a + b;
`ifdef FU_MUL_EN
         4'd1:  return a * b;
`else
         4'd1:  return a + b;
`endif
         4'd2:  return a - b;
         4'd3:  return a & b;
         4'd4:  return a | b;
         4'd5:  return a ^ b;
         4'd6:  return a << sh;
         4'd7:  return a >> sh;
         4'd8:  return DW'(sa >>> sh);
         4'd9:  return (sa < sb) ? a : b;
         4'd10: return (sa > sb) ? a : b;
         4'd11: return (sa < sb) ? 32'd1 : 32'd0;
         default: return a + b;
      endcase
   endfunction

   function automatic logic [DW-1:0] got_at(input int i);
      return (i < got_q.size()) ? got_q[i] : 32'hDEAD_BEEF;
   endfunction

   // ---------------- driver tasks ----------------
   // Entered at posedge+1 with inputs already set; checks at the falling
   // edge, advances the model, returns at the next posedge+1.
   task automatic run_cycle(output bit accepted);
      bit            exp_din_r, exp_dv, pop, wd_next;
      logic [DW-1:0] res;
      int            wlen;
      @(negedge clk);
      if (feedback) begin
         if (!m_in_window) begin
            exp_din_r   = 1'b0;
            m_acc       = initial_value;
            m_n         = 0;
            m_in_window = 1'b1;
         end else begin
            exp_din_r = (exp_q.size() < 2);
         end
      end else begin
         if (m_in_window) begin
            exp_din_r   = 1'b0;
            m_in_window = 1'b0;
         end else begin
            exp_din_r = (exp_q.size() < 2);
         end
      end
      check("din_r", 32'(din_r), 32'(exp_din_r));
      check("window_done", 32'(window_done), 32'(m_wd_exp));
      if (window_done) wd_seen++;
      exp_dv = (exp_q.size() > 0);
      check("dout_v", 32'(dout_v), 32'(exp_dv));
      if (exp_dv) check("dout", dout, exp_q[0]);
      pop      = exp_dv && dout_r;
      accepted = din_v && exp_din_r;
      wd_next  = 1'b0;
      if (pop) begin
         got_q.push_back(dout);
         void'(exp_q.pop_front());
      end
      if (accepted) begin
         if (feedback) begin
            res  = ref_op(alu_sel, din_1, m_acc);
            m_n++;
            wlen = (delay_value == 0) ? 1 : int'(delay_value);
            if (m_n >= wlen) begin
               exp_q.push_back(res);
               wd_next     = 1'b1;
               m_in_window = 1'b0;
            end else begin
               m_acc = res;
            end
         end else begin
            exp_q.push_back(ref_op(alu_sel, din_1, din_2));
         end
      end
      m_wd_exp = wd_next;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
      bit acc = 1'b0;
      din_v = 1'b1;
      din_1 = a;
      din_2 = b;
      for (int k = 0; k < 50 && !acc; k++) run_cycle(acc);
      check("send_accepted", 32'(acc), 32'd1);
      din_v = 1'b0;
   endtask

   task automatic idle(input int n);
      bit acc;
      din_v = 1'b0;
      for (int k = 0; k < n; k++) run_cycle(acc);
   endtask

   task automatic drain();
      bit acc;
      din_v  = 1'b0;
      dout_r = 1'b1;
      for (int k = 0; k < 50 && exp_q.size() > 0; k++) run_cycle(acc);
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   // Entered at posedge+1; rst rises mid-cycle, released at posedge+1.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      check("rst_dout_v", 32'(dout_v), 32'd0);
      check("rst_din_r", 32'(din_r), 32'd0);
      check("rst_dout", dout, 32'd0);
      check("rst_window_done", 32'(window_done), 32'd0);
      exp_q.delete();
      m_in_window = 1'b0;
      m_wd_exp    = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   function automatic logic [DW-1:0] rand_data();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      bit acc;
      @(posedge clk);
      #1;
      do_reset();

      // Streaming add, consecutive results.
      feedback = 1'b0; alu_sel = 4'd0; dout_r = 1'b1; got_q.delete();
      send(32'd5, 32'd7);
      send(32'hFFFF_FFFF, 32'd2);
      drain();
      check("stream_count", 32'(got_q.size()), 32'd2);
      check("stream_0", got_at(0), 32'd12);
      check("stream_1", got_at(1), 32'd1);

      // Backpressure with sub.
      alu_sel = 4'd2; dout_r = 1'b0; got_q.delete();
      send(32'd10, 32'd3);
      send(32'd9, 32'd4);
      din_v = 1'b1; din_1 = 32'd8; din_2 = 32'd8;
      run_cycle(acc);
      check("bp_blocked_0", 32'(acc), 32'd0);
      run_cycle(acc);
      check("bp_blocked_1", 32'(acc), 32'd0);
      dout_r = 1'b1;
      send(32'd8, 32'd8);
      drain();
      check("bp_count", 32'(got_q.size()), 32'd3);
      check("bp_0", got_at(0), 32'd7);
      check("bp_1", got_at(1), 32'd5);
      check("bp_2", got_at(2), 32'd0);

      // Feedback windows of 4, two back to back.
      feedback = 1'b1; initial_value = 32'd100; delay_value = 16'd4; alu_sel = 4'd0;
      got_q.delete(); wd_seen = 0;
      for (int w = 0; w < 2; w++)
         for (int i = 1; i <= 4; i++) send(32'(i), 32'd0);
      drain();
      check("fb_count", 32'(got_q.size()), 32'd2);
      check("fb_win0", got_at(0), 32'd110);
      check("fb_win1", got_at(1), 32'd110);
      check("fb_done_pulses", 32'(wd_seen), 32'd2);
      feedback = 1'b0;
      idle(2);

      // Edge opcodes.
      got_q.delete();
      alu_sel = 4'd6;  send(32'd1, 32'd35);
      alu_sel = 4'd8;  send(32'h8000_0000, 32'd4);
      alu_sel = 4'd9;  send(32'hFFFF_FFFF, 32'd3);
      alu_sel = 4'd11; send(32'hFFFF_FFFF, 32'd3);
      drain();
      check("shl", got_at(0), 32'd8);
      check("sar", got_at(1), 32'hF800_0000);
      check("min", got_at(2), 32'hFFFF_FFFF);
      check("lt", got_at(3), 32'd1);

      // delay_value 0 behaves as a window of one.
      feedback = 1'b1; delay_value = 16'd0; initial_value = 32'd100; alu_sel = 4'd0;
      got_q.delete();
      send(32'd5, 32'd0);
      send(32'd6, 32'd0);
      drain();
      check("delay0_0", got_at(0), 32'd105);
      check("delay0_1", got_at(1), 32'd106);
      feedback = 1'b0;
      idle(2);

      // Opcode 1 depends on the multiplier option.
      alu_sel = 4'd1; got_q.delete();
      send(32'd6, 32'd7);
      drain();
`ifdef FU_MUL_EN
      check("op1_mul", got_at(0), 32'd42);
`else
      check("op1_add", got_at(0), 32'd13);
`endif

      // Reset in the middle of a window with one buffered result.
      alu_sel = 4'd0; dout_r = 1'b0;
      send(32'd1, 32'd1);
      feedback = 1'b1; initial_value = 32'd100; delay_value = 16'd4;
      send(32'd1, 32'd0);
      send(32'd2, 32'd0);
      check("pre_rst_dout_v", 32'(dout_v), 32'd1);
      do_reset();
      dout_r = 1'b1; got_q.delete();
      for (int i = 1; i <= 4; i++) send(32'(i), 32'd0);
      drain();
      check("rst_restart_count", 32'(got_q.size()), 32'd1);
      check("rst_restart", got_at(0), 32'd110);
      feedback = 1'b0;
      idle(2);

      // Random phase.
      for (int seg = 0; seg < 30; seg++) begin
         feedback = 1'b0;
         idle(2);
         feedback      = ($urandom_range(0, 2) == 0);
         alu_sel       = 4'($urandom_range(0, 15));
         delay_value   = 16'($urandom_range(0, 5));
         initial_value = rand_data();
         for (int c = 0; c < int'($urandom_range(20, 120)); c++) begin
            din_v  = ($urandom_range(0, 3) != 0);
            din_1  = rand_data();
            din_2  = rand_data();
            dout_r = ($urandom_range(0, 3) != 0);
            if (!feedback) alu_sel = 4'($urandom_range(0, 15));
            run_cycle(acc);
         end
      end
      feedback = 1'b0;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
